// File: rtl/branch_predictor.sv
// Two-bit saturating-counter branch direction predictor with a misprediction counter.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history register into the lookup index.
module branch_predictor #(
   parameter int IDX_BITS = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                lookup_valid,
   input  logic [31:0]         lookup_pc,
   output logic                pred_valid,
   output logic                pred_taken,
   output logic [IDX_BITS-1:0] pred_idx,
   input  logic                upd_valid,
   input  logic [IDX_BITS-1:0] upd_idx,
   input  logic                upd_taken,
   input  logic                upd_predicted,
   output logic [31:0]         mispredicts
);

   // Valid-only handshakes: a lookup is taken whenever lookup_valid is high, an
   // update whenever upd_valid is high; there is no ready, both are accepted every cycle.
   localparam int DEPTH = 1 << IDX_BITS;

   logic [1:0]          ctr_q [DEPTH];
   logic [IDX_BITS-1:0] lk_idx;
   logic [31:0]         miss_cnt;
   logic                unused_pc_bits;

   assign unused_pc_bits = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
   logic [IDX_BITS-1:0] ghr;

   // The lookup sees the history as it stood before this cycle's update.
   assign lk_idx = lookup_pc[IDX_BITS+1:2] ^ ghr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ghr <= '0;
      end else if (upd_valid) begin
         ghr <= {ghr[IDX_BITS-2:0], upd_taken};
      end
   end
`else
   assign lk_idx = lookup_pc[IDX_BITS+1:2];
`endif

   // Counter table; a same-cycle lookup reads the pre-update value (no bypass).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ctr_q[i] <= 2'b01;
         end
      end else if (upd_valid) begin
         if (upd_taken && (ctr_q[upd_idx] != 2'b11)) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'b01;
         end else if (!upd_taken && (ctr_q[upd_idx] != 2'b00)) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'b01;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
         pred_idx   <= '0;
      end else begin
         pred_valid <= lookup_valid;
         if (lookup_valid) begin
            pred_taken <= ctr_q[lk_idx][1];
            pred_idx   <= lk_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miss_cnt <= '0;
      end else if (upd_valid && (upd_taken != upd_predicted)) begin
         miss_cnt <= miss_cnt + 32'd1;
      end
   end

   assign mispredicts = miss_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor against a behavioural table model.
module tb_branch_predictor;

   localparam int IDX_BITS = 6;
   localparam int N        = 1 << IDX_BITS;

   logic                clk;
   logic                rst_n;
   logic                lookup_valid;
   logic [31:0]         lookup_pc;
   logic                pred_valid;
   logic                pred_taken;
   logic [IDX_BITS-1:0] pred_idx;
   logic                upd_valid;
   logic [IDX_BITS-1:0] upd_idx;
   logic                upd_taken;
   logic                upd_predicted;
   logic [31:0]         mispredicts;

   branch_predictor #(.IDX_BITS(IDX_BITS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .lookup_valid (lookup_valid),
      .lookup_pc    (lookup_pc),
      .pred_valid   (pred_valid),
      .pred_taken   (pred_taken),
      .pred_idx     (pred_idx),
      .upd_valid    (upd_valid),
      .upd_idx      (upd_idx),
      .upd_taken    (upd_taken),
      .upd_predicted(upd_predicted),
      .mispredicts  (mispredicts)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model: counter values 0..3, history as a plain integer
   int          m_ctr [N];
   int          m_hist;
   bit          e_valid;
   bit          e_taken;
   int          e_idx;
   logic [31:0] e_miss;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_ctr[i] = 1;
      m_hist  = 0;
      e_valid = 0;
      e_taken = 0;
      e_idx   = 0;
      e_miss  = 0;
   endtask

   task automatic idle_inputs();
      lookup_valid  = 0;
      lookup_pc     = 0;
      upd_valid     = 0;
      upd_idx       = 0;
      upd_taken     = 0;
      upd_predicted = 0;
   endtask

   // One clock: drive, let the edge happen, advance the model, compare everything.
   task automatic step(input bit lv, input logic [31:0] pc, input bit uv, input int ui,
                       input bit ut, input bit up);
      int lidx;
      lookup_valid  = lv;
      lookup_pc     = pc;
      upd_valid     = uv;
      upd_idx       = ui[IDX_BITS-1:0];
      upd_taken     = ut;
      upd_predicted = up;
      lidx = ((int'(pc) >>> 2) ^ m_hist) & (N - 1);
      @(posedge clk);
      #1;
      e_valid = lv;
      if (lv) begin
         e_taken = (m_ctr[lidx] >= 2);
         e_idx   = lidx;
      end
      if (uv) begin
         if (ut) m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
         else    m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
         if (ut != up) e_miss = e_miss + 1;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
         m_hist = ((m_hist * 2) + int'(ut)) % N;
`endif
      end
      check("pred_valid", {31'b0, pred_valid}, {31'b0, e_valid});
      check("pred_taken", {31'b0, pred_taken}, {31'b0, e_taken});
      check("pred_idx", 32'(pred_idx), e_idx);
      check("mispredicts", mispredicts, e_miss);
   endtask

   task automatic upd(input int ui, input bit ut);
      step(0, 0, 1, ui, ut, ut);
   endtask

   task automatic look(input logic [31:0] pc);
      step(1, pc, 0, 0, 0, 0);
   endtask

   initial begin
      idle_inputs();
      rst_n = 0;
      model_reset();
      #12;
      check("reset_pred_valid", {31'b0, pred_valid}, 0);
      check("reset_mispredicts", mispredicts, 0);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
      upd(0, 1);
      look(32'h104);
      check("gshare_idx", 32'(pred_idx), 0);
`else
      look(32'h100);
      check("first_lookup_valid", {31'b0, pred_valid}, 1);
      check("first_lookup_taken", {31'b0, pred_taken}, 0);
      check("first_lookup_idx", 32'(pred_idx), 0);
      upd(0, 1);
      upd(0, 1);
      look(32'h100);
      check("trained_taken", {31'b0, pred_taken}, 1);
      for (int i = 0; i < 5; i++) upd(0, 1);
      upd(0, 0);
      look(32'h100);
      check("saturate_then_nt", {31'b0, pred_taken}, 1);
      step(1, 32'h104, 1, 1, 1, 1);
      check("no_bypass", {31'b0, pred_taken}, 0);
      look(32'h104);
      check("after_update", {31'b0, pred_taken}, 1);
      step(0, 0, 1, 5, 1, 0);
      step(0, 0, 1, 5, 1, 1);
      step(0, 0, 1, 5, 0, 1);
      step(0, 0, 1, 5, 0, 0);
      step(0, 0, 1, 5, 1, 0);
      check("mispredict_count", mispredicts, 3);
      force dut.miss_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.miss_cnt;
      e_miss = 32'hFFFF_FFFF;
      step(0, 0, 1, 7, 0, 1);
      check("mispredict_wrap", mispredicts, 0);
`endif

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, N - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // bias some entries upward so reset has trained state to clear
      for (int i = 0; i < 8; i++) begin
         upd(i, 1);
         upd(i, 1);
      end

      // asynchronous reset in the middle of a lookup stream
      lookup_valid = 1;
      lookup_pc    = 32'h0;
      @(posedge clk);
      #3;
      rst_n = 0;
      model_reset();
      #1;
      check("midreset_pred_valid", {31'b0, pred_valid}, 0);
      check("midreset_mispredicts", mispredicts, 0);
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      rst_n = 1;
      #1;
      check("release_pred_valid", {31'b0, pred_valid}, 0);
      @(posedge clk);
      #1;

      // every entry should read weak-NT: not taken, and one taken update flips it
      for (int i = 0; i < N; i++) begin
         look(32'(i) << 2);
         upd(i, 1);
         look(32'(i) << 2);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
         check("weak_nt_flip", {31'b0, pred_taken}, 1);
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
